// File: rtl/fsm_cpu.sv
// CPU-side sender of a 4-phase send/ack link: pushes dado_cpu onto dado_t whenever it differs from the last accepted word.
// Optional ack timeout with an ERR state is enabled by defining FSM_CPU_ACK_TIMEOUT_EN.
module fsm_cpu #(
    parameter int DATA_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] dado_cpu,
    input  logic [1:0]        ack,
    output logic [1:0]        send,
    output logic [DATA_W-1:0] dado_t
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        REL  = 2'b10,
        ERR  = 2'b11
    } state_t;

    localparam logic [1:0] SEND_IDLE = 2'b00;
    localparam logic [1:0] SEND_REQ  = 2'b01;
    localparam logic [1:0] SEND_REL  = 2'b10;
    localparam logic [1:0] SEND_ERR  = 2'b11;

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("fsm_cpu: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    state_t                        state_q, state_d;
    logic [1:0]                    send_q, send_d;
    logic [DATA_W-1:0]             dado_t_q, dado_t_d;
    logic [DATA_W-1:0]             last_sent_q, last_sent_d;
    logic                          retry_q, retry_d;
    logic [SYNC_STAGES-1:0][1:0]   sync_q, sync_d;
    logic [1:0]                    ack_s;
    logic                          timeout;

`ifdef FSM_CPU_ACK_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout = (state_q == REQ || state_q == REL) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    assign sync_d = {sync_q[SYNC_STAGES-2:0], ack};
    assign ack_s  = sync_q[SYNC_STAGES-1];
    assign send   = send_q;
    assign dado_t = dado_t_q;

    always_comb begin
        state_d     = state_q;
        send_d      = send_q;
        dado_t_d    = dado_t_q;
        last_sent_d = last_sent_q;
        retry_d     = retry_q;

        case (state_q)
            IDLE: begin
                if (dado_cpu != last_sent_q) begin
                    dado_t_d = dado_cpu;
                    send_d   = SEND_REQ;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (ack_s == 2'b01) begin
                    last_sent_d = dado_t_q;
                    retry_d     = 1'b0;
                    send_d      = SEND_REL;
                    state_d     = REL;
                end else if (ack_s[1]) begin
                    retry_d = 1'b1;
                    send_d  = SEND_REL;
                    state_d = REL;
                end
            end
            REL: begin
                if (ack_s == 2'b00) begin
                    send_d  = retry_q ? SEND_REQ : SEND_IDLE;
                    state_d = retry_q ? REQ : IDLE;
                end
            end
            default: begin
                // ERR leaves last_sent alone so the same word is offered again from IDLE.
                if (ack_s == 2'b00) begin
                    send_d  = SEND_IDLE;
                    state_d = IDLE;
                end
            end
        endcase

        // A genuine ack on the deadline cycle wins over the timeout.
        if (timeout && state_d == state_q) begin
            send_d  = SEND_ERR;
            state_d = ERR;
        end
    end

`ifdef FSM_CPU_ACK_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            send_q      <= SEND_IDLE;
            dado_t_q    <= '0;
            last_sent_q <= '0;
            retry_q     <= 1'b0;
            sync_q      <= '0;
`ifdef FSM_CPU_ACK_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            send_q      <= send_d;
            dado_t_q    <= dado_t_d;
            last_sent_q <= last_sent_d;
            retry_q     <= retry_d;
            sync_q      <= sync_d;
`ifdef FSM_CPU_ACK_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fsm_cpu.sv
// Directed bench for fsm_cpu: reset, basic transfer, back-to-back, reject/retry, mid-transfer reset and timeout.
// Timeout expectations follow FSM_CPU_ACK_TIMEOUT_EN with TIMEOUT_CYC=8.
module tb_fsm_cpu;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] dado_cpu;
    logic [1:0] ack;
    logic [1:0] send;
    logic [1:0] dado_t;

    int check_count = 0;
    int error_count = 0;

    fsm_cpu #(
        .DATA_W      (2),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .dado_cpu (dado_cpu),
        .ack      (ack),
        .send     (send),
        .dado_t   (dado_t)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [1:0] actual, input logic [1:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    // Drive inputs, then let the given number of rising edges pass; outputs are read 1ns after the last edge.
    task automatic applyStimulus(input logic rst_n, input logic [1:0] data, input logic [1:0] ack_v, input int cycles);
        reset    = rst_n;
        dado_cpu = data;
        ack      = ack_v;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        dado_cpu = 2'b00;
        ack      = 2'b00;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 2'b00, 2'b00, 1);
            checkOutput("reset_send", send, 2'b00);
            checkOutput("reset_dado_t", dado_t, 2'b00);
        end

        applyStimulus(1'b1, 2'b00, 2'b00, 2);
        checkOutput("zero_no_start", send, 2'b00);

        // Basic transfer of 1
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        checkOutput("basic_req_send", send, 2'b01);
        checkOutput("basic_req_data", dado_t, 2'b01);
        applyStimulus(1'b1, 2'b01, 2'b01, 2);
        checkOutput("basic_ack_sync_wait", send, 2'b01);
        applyStimulus(1'b1, 2'b01, 2'b01, 1);
        checkOutput("basic_rel", send, 2'b10);
        applyStimulus(1'b1, 2'b01, 2'b00, 2);
        checkOutput("basic_rel_hold", send, 2'b10);
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        checkOutput("basic_idle", send, 2'b00);
        applyStimulus(1'b1, 2'b01, 2'b00, 3);
        checkOutput("basic_no_restart", send, 2'b00);
        checkOutput("basic_dado_t_hold", dado_t, 2'b01);

        // Back-to-back: value 2, then dado_cpu drops to 0 during REL
        applyStimulus(1'b1, 2'b10, 2'b00, 1);
        checkOutput("b2b_req2_data", dado_t, 2'b10);
        applyStimulus(1'b1, 2'b10, 2'b01, 3);
        checkOutput("b2b_rel2", send, 2'b10);
        applyStimulus(1'b1, 2'b00, 2'b00, 3);
        checkOutput("b2b_idle", send, 2'b00);
        checkOutput("b2b_idle_data_hold", dado_t, 2'b10);
        applyStimulus(1'b1, 2'b00, 2'b00, 1);
        checkOutput("b2b_req0_send", send, 2'b01);
        checkOutput("b2b_req0_data", dado_t, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b01, 3);
        checkOutput("b2b_rel0", send, 2'b10);
        applyStimulus(1'b1, 2'b00, 2'b00, 3);
        checkOutput("b2b_idle0", send, 2'b00);

        // One-cycle pulse to 1 in IDLE, then back to 0 while busy
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        checkOutput("pulse_req_send", send, 2'b01);
        checkOutput("pulse_req_data", dado_t, 2'b01);
        applyStimulus(1'b1, 2'b00, 2'b00, 2);
        checkOutput("pulse_data_stable", dado_t, 2'b01);
        applyStimulus(1'b1, 2'b00, 2'b01, 3);
        checkOutput("pulse_rel", send, 2'b10);
        applyStimulus(1'b1, 2'b00, 2'b00, 3);
        checkOutput("pulse_idle", send, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b00, 1);
        checkOutput("latest_req_send", send, 2'b01);
        checkOutput("latest_req_data", dado_t, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b01, 3);
        applyStimulus(1'b1, 2'b00, 2'b00, 3);
        checkOutput("latest_idle", send, 2'b00);

        // Reject with 10, then 11, then accept
        applyStimulus(1'b1, 2'b11, 2'b00, 1);
        checkOutput("rej_req_data", dado_t, 2'b11);
        applyStimulus(1'b1, 2'b11, 2'b10, 3);
        checkOutput("rej10_rel", send, 2'b10);
        applyStimulus(1'b1, 2'b11, 2'b00, 3);
        checkOutput("rej10_retry_send", send, 2'b01);
        checkOutput("rej10_retry_data", dado_t, 2'b11);
        applyStimulus(1'b1, 2'b11, 2'b11, 3);
        checkOutput("rej11_rel", send, 2'b10);
        applyStimulus(1'b1, 2'b11, 2'b00, 3);
        checkOutput("rej11_retry_send", send, 2'b01);
        applyStimulus(1'b1, 2'b11, 2'b01, 3);
        checkOutput("rej_accept_rel", send, 2'b10);
        applyStimulus(1'b1, 2'b11, 2'b00, 3);
        checkOutput("rej_accept_idle", send, 2'b00);
        applyStimulus(1'b1, 2'b11, 2'b00, 2);
        checkOutput("rej_no_restart", send, 2'b00);

        // Reset in the middle of REQ
        applyStimulus(1'b1, 2'b10, 2'b00, 1);
        checkOutput("midrst_req", send, 2'b01);
        applyStimulus(1'b0, 2'b10, 2'b00, 1);
        checkOutput("midrst_send", send, 2'b00);
        checkOutput("midrst_data", dado_t, 2'b00);
        applyStimulus(1'b1, 2'b00, 2'b00, 2);
        checkOutput("midrst_idle", send, 2'b00);

        // Ack stuck at 00 in REQ
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        checkOutput("to_req", send, 2'b01);
`ifdef FSM_CPU_ACK_TIMEOUT_EN
        applyStimulus(1'b1, 2'b01, 2'b00, 7);
        checkOutput("to_before_deadline", send, 2'b01);
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        checkOutput("to_err", send, 2'b11);
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        checkOutput("to_idle", send, 2'b00);
        applyStimulus(1'b1, 2'b01, 2'b00, 1);
        checkOutput("to_resend_send", send, 2'b01);
        checkOutput("to_resend_data", dado_t, 2'b01);
`else
        applyStimulus(1'b1, 2'b01, 2'b00, 20);
        checkOutput("noto_hold_send", send, 2'b01);
        checkOutput("noto_hold_data", dado_t, 2'b01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
